// File: rtl/serv_lsu_pkg.sv
// Shared definitions for the SERV load/store unit controller: FSM states and
// helpers that derive the beat count and counter width from the serial width.
package serv_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_BUS   = 3'd2,
    S_SHIFT = 3'd3,
    S_TRAP  = 3'd4
  } lsu_state_t;

  function automatic int lsu_beats(input int w);
    return 32 / w;
  endfunction

  function automatic int lsu_cnt_w(input int w);
    return $clog2(32 / w);
  endfunction

endpackage

// File: rtl/serv_lsu_cnt.sv
// Beat counter for the serial shift phases; wraps naturally after 2**CW beats
// and reports its two MSBs as the byte index of the current beat.
module serv_lsu_cnt #(
  parameter int CW = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_clr,
  output logic       o_wrap,
  output logic [1:0] o_msb
);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign o_wrap = &cnt;
  assign o_msb  = cnt[CW-1 -: 2];

endmodule

// File: rtl/serv_lsu_ctrl.sv
// Load/store sequencer: accepts a request, optionally traps misaligned accesses,
// shifts store data out, runs one data-bus cycle and shifts load data in.
module serv_lsu_ctrl
  import serv_lsu_pkg::*;
#(
  parameter int WITH_CSR = 1,
  parameter int W        = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  logic       i_we,
  input  logic       i_word,
  input  logic       i_half,
  input  logic [1:0] i_lsb,
  output logic       o_ready,
  output logic       o_misalign,
  output logic       o_wb_cyc,
  output logic       o_wb_we,
  output logic [3:0] o_wb_sel,
  input  logic       i_wb_ack,
  output logic       o_shift_en,
  output logic [1:0] o_bytecnt,
  output logic       o_ld_capture,
  output logic       o_done
);

  localparam int CW = lsu_cnt_w(W);

  if (W != 1 && W != 4) begin : g_bad_w
    $error("serv_lsu_ctrl: W must be 1 or 4");
  end

  lsu_state_t state, state_nxt;
  logic       we_q, word_q, half_q;
  logic [1:0] lsb_q;
  logic       accept;
  logic       misaligned;
  logic       cnt_en, cnt_clr, cnt_wrap;
  logic [1:0] cnt_msb;

  assign misaligned = (i_lsb[0] & (i_word | i_half)) | (i_lsb[1] & i_word);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      we_q   <= 1'b0;
      word_q <= 1'b0;
      half_q <= 1'b0;
      lsb_q  <= 2'b00;
    end else if (accept) begin
      we_q   <= i_we;
      word_q <= i_word;
      half_q <= i_half;
      lsb_q  <= i_lsb;
    end
  end

  // Only PREP and SHIFT advance the beat counter; any other state holds it at 0
  assign cnt_en  = (state == S_PREP) || (state == S_SHIFT);
  assign cnt_clr = !cnt_en;

  serv_lsu_cnt #(
    .CW(CW)
  ) u_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (cnt_en),
    .i_clr  (cnt_clr),
    .o_wrap (cnt_wrap),
    .o_msb  (cnt_msb)
  );

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    o_misalign   = 1'b0;
    o_wb_cyc     = 1'b0;
    o_shift_en   = 1'b0;
    o_ld_capture = 1'b0;
    o_done       = 1'b0;
    case (state)
      S_IDLE: begin
        // Request is gated by reset so no acceptance pulse leaks out while held
        if (i_req && i_rst_n) begin
          if ((WITH_CSR != 0) && misaligned) begin
            state_nxt = S_TRAP;
          end else begin
            accept    = 1'b1;
            state_nxt = i_we ? S_PREP : S_BUS;
          end
        end
      end
      S_PREP: begin
        o_shift_en = 1'b1;
        if (cnt_wrap) state_nxt = S_BUS;
      end
      S_BUS: begin
        o_wb_cyc = 1'b1;
        if (i_wb_ack) begin
          if (we_q) begin
            o_done    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            o_ld_capture = 1'b1;
            state_nxt    = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        o_shift_en = 1'b1;
        if (cnt_wrap) begin
          o_done    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_TRAP: begin
        o_misalign = 1'b1;
        o_done     = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_ready   = accept;
  assign o_wb_we   = o_wb_cyc & we_q;
  assign o_bytecnt = cnt_en ? cnt_msb : 2'b00;

  always_comb begin
    o_wb_sel = 4'b0000;
    if (o_wb_cyc) begin
      if (word_q) begin
        o_wb_sel = 4'b1111;
      end else if (half_q) begin
        o_wb_sel = lsb_q[1] ? 4'b1100 : 4'b0011;
      end else begin
        o_wb_sel = 4'b0001 << lsb_q;
      end
    end
  end

endmodule
